// File: rtl/fwd_pkg.sv
// Shared encodings and types for the EX-stage forwarding and load-use hazard unit.
package fwd_pkg;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;
    localparam logic [1:0] FWD_RET = 2'd3;

    localparam int unsigned PERF_W = 16;

    typedef enum logic {
        S_IDLE,
        S_STALL
    } stateT;

endpackage

// File: rtl/fwd_select.sv
// Priority bypass comparator for one EX operand: MEM, then WB, then RET, else register file.
module fwd_select
    import fwd_pkg::*;
#(
    parameter int unsigned ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] srcReg,
    input  logic [ADDR_W-1:0] memDest,
    input  logic              memWrite,
    input  logic [ADDR_W-1:0] wbDest,
    input  logic              wbWrite,
    input  logic [ADDR_W-1:0] retDest,
    input  logic              retWrite,
    output logic [1:0]        fwdSel
);

    logic srcNonZero;

    assign srcNonZero = (srcReg != '0);

    always_comb begin
        fwdSel = FWD_RF;
        if (srcNonZero && memWrite && (memDest == srcReg)) begin
            fwdSel = FWD_MEM;
        end else if (srcNonZero && wbWrite && (wbDest == srcReg)) begin
            fwdSel = FWD_WB;
        end else if (srcNonZero && retWrite && (retDest == srcReg)) begin
            fwdSel = FWD_RET;
        end
    end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// EX-stage bypass selects plus load-use stall control with a saturating stall-cycle counter.
module forwarding_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned ADDR_W            = 5,
    parameter int unsigned NUM_SRC           = 2,
    parameter int unsigned LOAD_STALL_CYCLES = 1
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [NUM_SRC*ADDR_W-1:0] IDU_SrcReg,
    input  logic [NUM_SRC-1:0]        IDU_SrcUsed,
    input  logic [NUM_SRC*ADDR_W-1:0] EXU_SrcReg,
    input  logic [ADDR_W-1:0]         EXU_DestReg,
    input  logic                      EXU_RegWrite,
    input  logic                      EXU_MemRead,
    input  logic [ADDR_W-1:0]         MEM_DestReg,
    input  logic                      MEM_RegWrite,
    input  logic [ADDR_W-1:0]         WB_DestReg,
    input  logic                      WB_RegWrite,
    input  logic                      Flush,
    output logic [2*NUM_SRC-1:0]      EXU_FwdSel,
    output logic                      PC_Stall,
    output logic                      IFID_Stall,
    output logic                      IDEX_Bubble,
    output logic [15:0]               PerfStallCycles
);

    localparam logic [2:0] StallInit  = 3'(LOAD_STALL_CYCLES - 1);
    localparam bit         MultiCycle = (LOAD_STALL_CYCLES > 1);

    stateT               stateQ, stateD;
    logic [2:0]          cntQ, cntD;
    logic [ADDR_W-1:0]   retDestQ;
    logic                retWriteQ;
    logic [PERF_W-1:0]   perfQ;
    logic [2*NUM_SRC-1:0] fwdSelRaw;
    logic                det;
    logic                stall;

    for (genvar i = 0; i < NUM_SRC; i++) begin : gSrc
        fwd_select #(
            .ADDR_W(ADDR_W)
        ) uSel (
            .srcReg  (EXU_SrcReg[i*ADDR_W +: ADDR_W]),
            .memDest (MEM_DestReg),
            .memWrite(MEM_RegWrite),
            .wbDest  (WB_DestReg),
            .wbWrite (WB_RegWrite),
            .retDest (retDestQ),
            .retWrite(retWriteQ),
            .fwdSel  (fwdSelRaw[2*i +: 2])
        );
    end

    always_comb begin
        det = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (IDU_SrcUsed[i] && (IDU_SrcReg[i*ADDR_W +: ADDR_W] == EXU_DestReg)) begin
                det = 1'b1;
            end
        end
        det = det && EXU_MemRead && EXU_RegWrite && (EXU_DestReg != '0);
    end

    // RET mirrors last cycle's WB write so a same-cycle regfile read/write still sees it.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            stateQ    <= S_IDLE;
            cntQ      <= '0;
            retDestQ  <= '0;
            retWriteQ <= 1'b0;
            perfQ     <= '0;
        end else begin
            stateQ    <= stateD;
            cntQ      <= cntD;
            retDestQ  <= WB_DestReg;
            retWriteQ <= WB_RegWrite;
            if (stall && (perfQ != '1)) begin
                perfQ <= perfQ + 1'b1;
            end
        end
    end

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        if (Flush) begin
            stateD = S_IDLE;
            cntD   = '0;
        end else begin
            unique case (stateQ)
                S_IDLE: begin
                    if (det && MultiCycle) begin
                        stateD = S_STALL;
                        cntD   = StallInit;
                    end
                end
                S_STALL: begin
                    cntD = cntQ - 1'b1;
                    if (cntQ == 3'd1) begin
                        stateD = S_IDLE;
                        cntD   = '0;
                    end
                end
                default: begin
                    stateD = S_IDLE;
                    cntD   = '0;
                end
            endcase
        end
    end

    always_comb begin
        stall           = !Rst && !Flush && (((stateQ == S_IDLE) && det) || (stateQ == S_STALL));
        PC_Stall        = stall;
        IFID_Stall      = stall;
        IDEX_Bubble     = stall;
        EXU_FwdSel      = Rst ? '0 : fwdSelRaw;
        PerfStallCycles = Rst ? '0 : perfQ;
    end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed checks of bypass selection and load-use stall control for 1- and 3-cycle stall builds.
module tb_forwarding_hazard_unit;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [9:0]  IDU_SrcReg;
    logic [1:0]  IDU_SrcUsed;
    logic [9:0]  EXU_SrcReg;
    logic [4:0]  EXU_DestReg;
    logic        EXU_RegWrite;
    logic        EXU_MemRead;
    logic [4:0]  MEM_DestReg;
    logic        MEM_RegWrite;
    logic [4:0]  WB_DestReg;
    logic        WB_RegWrite;
    logic        Flush;

    logic [3:0]  fwdSel1, fwdSel3;
    logic        pcStall1, ifidStall1, bubble1, pcStall3, ifidStall3, bubble3;
    logic [15:0] perf1, perf3;

    int nChecks = 0;
    int nFails  = 0;

    always #5 Clk = ~Clk;

    forwarding_hazard_unit #(
        .ADDR_W(5), .NUM_SRC(2), .LOAD_STALL_CYCLES(1)
    ) dut1 (
        .Clk(Clk), .Rst(Rst), .IDU_SrcReg(IDU_SrcReg), .IDU_SrcUsed(IDU_SrcUsed),
        .EXU_SrcReg(EXU_SrcReg), .EXU_DestReg(EXU_DestReg), .EXU_RegWrite(EXU_RegWrite),
        .EXU_MemRead(EXU_MemRead), .MEM_DestReg(MEM_DestReg), .MEM_RegWrite(MEM_RegWrite),
        .WB_DestReg(WB_DestReg), .WB_RegWrite(WB_RegWrite), .Flush(Flush),
        .EXU_FwdSel(fwdSel1), .PC_Stall(pcStall1), .IFID_Stall(ifidStall1),
        .IDEX_Bubble(bubble1), .PerfStallCycles(perf1)
    );

    forwarding_hazard_unit #(
        .ADDR_W(5), .NUM_SRC(2), .LOAD_STALL_CYCLES(3)
    ) dut3 (
        .Clk(Clk), .Rst(Rst), .IDU_SrcReg(IDU_SrcReg), .IDU_SrcUsed(IDU_SrcUsed),
        .EXU_SrcReg(EXU_SrcReg), .EXU_DestReg(EXU_DestReg), .EXU_RegWrite(EXU_RegWrite),
        .EXU_MemRead(EXU_MemRead), .MEM_DestReg(MEM_DestReg), .MEM_RegWrite(MEM_RegWrite),
        .WB_DestReg(WB_DestReg), .WB_RegWrite(WB_RegWrite), .Flush(Flush),
        .EXU_FwdSel(fwdSel3), .PC_Stall(pcStall3), .IFID_Stall(ifidStall3),
        .IDEX_Bubble(bubble3), .PerfStallCycles(perf3)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Stall outputs of one build packed as {PC, IFID, bubble}.
    function automatic logic [2:0] st1();
        return {pcStall1, ifidStall1, bubble1};
    endfunction

    function automatic logic [2:0] st3();
        return {pcStall3, ifidStall3, bubble3};
    endfunction

    task automatic doReset();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
    endtask

    task automatic setLoadR5(input logic on);
        EXU_MemRead  = on;
        EXU_RegWrite = on;
        EXU_DestReg  = 5'd5;
        IDU_SrcReg   = {5'd0, 5'd5};
        IDU_SrcUsed  = 2'b01;
    endtask

    initial begin
        Rst = 1'b1; IDU_SrcReg = '0; IDU_SrcUsed = '0; EXU_SrcReg = '0; EXU_DestReg = '0;
        EXU_RegWrite = 0; EXU_MemRead = 0; MEM_DestReg = '0; MEM_RegWrite = 0;
        WB_DestReg = '0; WB_RegWrite = 0; Flush = 0;

        // Outputs forced low while in reset even with a live forwarding match.
        tick();
        EXU_SrcReg = {5'd0, 5'd8}; MEM_DestReg = 5'd8; MEM_RegWrite = 1;
        setLoadR5(1'b1);
        settle();
        checkVal("rst_fwdsel", 32'(fwdSel1), 32'h0);
        checkVal("rst_stall", 32'(st1()), 32'h0);
        checkVal("rst_perf", 32'(perf1), 32'h0);
        setLoadR5(1'b0);
        tick();
        Rst = 1'b0;
        settle();
        checkVal("reset_perf", 32'(perf3), 32'h0);
        checkVal("reset_stall", 32'(st3()), 32'h0);

        // Plain forwarding: MEM beats WB, then WB alone.
        WB_DestReg = 5'd8; WB_RegWrite = 1;
        settle();
        checkVal("fwd_mem_wins", 32'(fwdSel1), 32'h1);
        MEM_RegWrite = 0;
        settle();
        checkVal("fwd_wb", 32'(fwdSel1), 32'h2);
        EXU_SrcReg = {5'd6, 5'd4}; MEM_DestReg = 5'd6; MEM_RegWrite = 1; WB_DestReg = 5'd4;
        settle();
        checkVal("fwd_two_ops", 32'(fwdSel3), 32'h6);

        // Register zero never forwarded, from any stage.
        EXU_SrcReg = '0; MEM_DestReg = '0; WB_DestReg = '0;
        tick();
        checkVal("fwd_r0", 32'(fwdSel1), 32'h0);

        // WB r9 in cycle t is seen through RET in t+1.
        WB_DestReg = 5'd9; WB_RegWrite = 1; MEM_RegWrite = 0;
        tick();
        WB_DestReg = 5'd3; WB_RegWrite = 0; EXU_SrcReg = {5'd9, 5'd0};
        settle();
        checkVal("fwd_ret", 32'(fwdSel1), 32'hC);
        tick();
        checkVal("fwd_ret_gone", 32'(fwdSel1), 32'h0);

        // Single-cycle load-use stall.
        doReset();
        setLoadR5(1'b1);
        settle();
        checkVal("lu1_stall", 32'(st1()), 32'h7);
        tick();
        setLoadR5(1'b0);
        settle();
        checkVal("lu1_release", 32'(st1()), 32'h0);
        checkVal("lu1_perf", 32'(perf1), 32'h1);
        setLoadR5(1'b1); IDU_SrcUsed = 2'b00;
        settle();
        checkVal("lu1_unused", 32'(st1()), 32'h0);
        IDU_SrcReg = {5'd5, 5'd7}; IDU_SrcUsed = 2'b10;
        settle();
        checkVal("lu1_op1", 32'(st1()), 32'h7);
        EXU_DestReg = 5'd0; IDU_SrcReg = '0; IDU_SrcUsed = 2'b11;
        settle();
        checkVal("lu1_r0_load", 32'(st1()), 32'h0);

        // Three-cycle stall window.
        doReset();
        setLoadR5(1'b1);
        settle();
        checkVal("lu3_t0", 32'(st3()), 32'h7);
        tick();
        checkVal("lu3_t1", 32'(st3()), 32'h7);
        tick();
        checkVal("lu3_t2", 32'(st3()), 32'h7);
        tick();
        setLoadR5(1'b0);
        settle();
        checkVal("lu3_t3", 32'(st3()), 32'h0);
        checkVal("lu3_perf", 32'(perf3), 32'h3);

        // Flush coincident with detect wins.
        doReset();
        setLoadR5(1'b1); Flush = 1;
        settle();
        checkVal("flush_det_3", 32'(st3()), 32'h0);
        checkVal("flush_det_1", 32'(st1()), 32'h0);
        tick();
        Flush = 0; setLoadR5(1'b0);
        settle();
        checkVal("flush_det_next", 32'(st3()), 32'h0);
        checkVal("flush_det_perf", 32'(perf3), 32'h0);

        // Flush in the second cycle of a 3-cycle stall.
        doReset();
        setLoadR5(1'b1);
        tick();
        Flush = 1;
        settle();
        checkVal("flush_mid", 32'(st3()), 32'h0);
        tick();
        Flush = 0; setLoadR5(1'b0);
        settle();
        checkVal("flush_mid_idle", 32'(st3()), 32'h0);
        checkVal("flush_mid_perf", 32'(perf3), 32'h1);

        // Reset mid-stall.
        doReset();
        setLoadR5(1'b1);
        tick();
        checkVal("rstmid_pre", 32'(perf3), 32'h1);
        Rst = 1; EXU_SrcReg = {5'd0, 5'd8}; MEM_DestReg = 5'd8; MEM_RegWrite = 1;
        settle();
        checkVal("rstmid_stall", 32'(st3()), 32'h0);
        checkVal("rstmid_fwd", 32'(fwdSel3), 32'h0);
        tick();
        Rst = 0; setLoadR5(1'b0);
        settle();
        checkVal("rstmid_after", 32'(st3()), 32'h0);
        checkVal("rstmid_perf", 32'(perf3), 32'h0);

        // Saturation.
        setLoadR5(1'b1);
        repeat (70000) @(posedge Clk);
        #1;
        checkVal("sat_perf1", 32'(perf1), 32'hFFFF);
        checkVal("sat_perf3", 32'(perf3), 32'hFFFF);
        checkVal("sat_stall", 32'(st1()), 32'h7);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
